// File: rtl/cpu_div_sequencer.sv
// cpu_div_sequencer
//   Multi-cycle controller for the RV32M divide ops (DIV, DIVU, REM, REMU).
//   An iterative restoring divider that produces one quotient bit per cycle.
//   It holds busy while the execute stage stalls, then returns one result with
//   a single-cycle done pulse.
//
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   start      in   1      request; accepted in IDLE, or in the done cycle
//   op         in   2      00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0])
//   operand_a  in   WIDTH  dividend (rs1)
//   operand_b  in   WIDTH  divisor (rs2)
//   flush      in   1      abort the operation in flight; wins over start
//   busy       out  1      high while iterating (RUN); never high with done
//   done       out  1      one-cycle pulse; result is valid in the same cycle
//   result     out  WIDTH  quotient or remainder; held until the next done
//   dbg_state  out  2      current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: start is sampled at a rising edge when the FSM is in IDLE or FIX
// and flush is low. done is a combinational decode of FIX (gated by flush). In
// that cycle the FSM is already committed to return to IDLE, so a start held in
// the done cycle is accepted and runs back-to-back.
module cpu_div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sel_rem_q, sel_rem_d;   // op[1]: return remainder
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             special_q, special_d;
  logic [WIDTH-1:0] spec_val_q, spec_val_d;
  logic [WIDTH-1:0] result_q, result_d;

  // Datapath helpers
  logic [WIDTH:0]   rem_shift;    // one bit wider so the compare never loses a carry
  logic             rem_ge;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] quo_fix, rem_fix, fix_val;
  logic             accept;
  logic             is_signed, a_neg, b_neg, b_zero, ovf;

  always_comb begin
    rem_shift = {rem_q, quo_q[WIDTH-1]};
    rem_ge    = rem_shift >= {1'b0, div_q};
    // The difference is below 2^WIDTH whenever it is used, so WIDTH bits suffice.
    rem_sub   = rem_shift[WIDTH-1:0] - div_q;
    quo_fix   = neg_quo_q ? -quo_q : quo_q;
    rem_fix   = neg_rem_q ? -rem_q : rem_q;
    if (special_q) fix_val = spec_val_q;
    else           fix_val = sel_rem_q ? rem_fix : quo_fix;

    is_signed = ~op[0];
    a_neg     = is_signed & operand_a[WIDTH-1];
    b_neg     = is_signed & operand_b[WIDTH-1];
    b_zero    = (operand_b == '0);
    ovf       = is_signed && (operand_a == MIN_INT) && (operand_b == '1);
  end

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    sel_rem_d  = sel_rem_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    special_d  = special_q;
    spec_val_d = spec_val_q;
    result_d   = result_q;

    busy      = (state_q == S_RUN);
    done      = (state_q == S_FIX) && !flush;
    result    = done ? fix_val : result_q;
    dbg_state = state_q;
    accept    = start && !flush && ((state_q == S_IDLE) || (state_q == S_FIX));

    case (state_q)
      S_IDLE: ;
      S_RUN: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          quo_d = {quo_q[WIDTH-2:0], rem_ge};
          rem_d = rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - CW'(1);
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!flush) result_d = fix_val;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      sel_rem_d = op[1];
      neg_quo_d = a_neg ^ b_neg;
      neg_rem_d = a_neg;
      // Negating MIN_INT yields MIN_INT, which is the correct unsigned magnitude.
      quo_d     = a_neg ? -operand_a : operand_a;
      div_d     = b_neg ? -operand_b : operand_b;
      rem_d     = '0;
      cnt_d     = CW'(WIDTH - 1);
      special_d = b_zero | ovf;
      if (b_zero)   spec_val_d = op[1] ? operand_a : '1;
      else          spec_val_d = op[1] ? '0 : MIN_INT;
      state_d   = (b_zero | ovf) ? S_FIX : S_RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      quo_q      <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      sel_rem_q  <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      special_q  <= 1'b0;
      spec_val_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      sel_rem_q  <= sel_rem_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      special_q  <= special_d;
      spec_val_q <= spec_val_d;
      result_q   <= result_d;
    end
  end

endmodule

// File: tb/tb_cpu_div_sequencer.sv
module tb_cpu_div_sequencer;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [1:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  cpu_div_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .dbg_state (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts one op, follows it to done, and checks latency, busy shape and result.
  // The caller sits at a negedge; returns at the negedge after the done cycle.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
    int n;
    int busy_cnt;
    logic got;
    logic [31:0] res;
    logic busy_at_done;
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = 1'b0;
    n = 0; busy_cnt = 0; got = 1'b0; res = '0; busy_at_done = 1'b0;
    while (!got && n < 60) begin
      n++;
      if (done) begin
        got = 1'b1; res = result; busy_at_done = busy;
      end else begin
        if (busy) busy_cnt++;
        @(negedge clk);
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(exp_lat));
    check({tag, "_result"}, res, exp_r);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check({tag, "_busy_at_done"}, 32'(busy_at_done), 32'd0);
    @(negedge clk);
    check({tag, "_result_held"}, result, exp_r);
    check({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  // Directed sequence
  initial begin
    int n;
    int dones;
    logic got;
    logic [31:0] res;

    rst_n = 1'b0; start = 1'b0; op = 2'b00; operand_a = '0; operand_b = '0; flush = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Unsigned basics
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_op("divu_max_1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33);
    run_op("divu_max_maxm1", OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("remu_max_maxm1", OP_REMU, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 33);

    // Signed sign correction
    run_op("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
    run_op("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 32'hC000_0000, 33);
    run_op("div_min_3", OP_DIV, 32'h8000_0000, 32'd3, 32'hD555_5556, 33);
    run_op("rem_min_3", OP_REM, 32'h8000_0000, 32'd3, 32'hFFFF_FFFE, 33);

    // Divide by zero
    run_op("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5, 1);
    run_op("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("rem_m5_0", OP_REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);

    // Signed overflow and the same operands unsigned
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_ovf_ops", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33);
    run_op("remu_ovf_ops", OP_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);

    // start while busy is ignored: 1000/9 = 111 survives a stray start at T+5
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n = 0; got = 1'b0; res = '0;
    while (!got && n < 60) begin
      n++;
      if (n == 5) begin
        start = 1'b1; op = OP_DIV; operand_a = 32'd50; operand_b = 32'd5;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1'b1; res = result;
      end else begin
        @(negedge clk);
      end
    end
    start = 1'b0;
    check("ignore_start_latency", 32'(n), 32'd33);
    check("ignore_start_result", res, 32'd111);
    @(negedge clk);
    check("ignore_start_idle", 32'(dbg_state), 32'd0);
    check("ignore_start_busy", 32'(busy), 32'd0);

    // Back-to-back: a start held in the done cycle launches the next op
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; operand_a = 32'd100; operand_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 60) begin
      n++;
      if (done) got = 1'b1;
      else @(negedge clk);
    end
    check("b2b_first_latency", 32'(n), 32'd33);
    check("b2b_first_result", result, 32'd14);
    start = 1'b1; op = OP_REMU;
    @(negedge clk);
    start = 1'b0;
    n = 0; got = 1'b0; res = '0;
    while (!got && n < 60) begin
      n++;
      if (done) begin
        got = 1'b1; res = result;
      end else begin
        @(negedge clk);
      end
    end
    check("b2b_second_latency", 32'(n), 32'd33);
    check("b2b_second_result", res, 32'd2);
    @(negedge clk);

    // Flush at T+10: idle at T+11, no done, result keeps 2
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 10; i++) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_state", 32'(dbg_state), 32'd0);
    check("flush_result", result, 32'd2);
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("flush_no_done", 32'(dones), 32'd0);
    check("flush_result_kept", result, 32'd2);

    // Flush during the FIX cycle of a special case suppresses done
    start = 1'b1; op = OP_DIV; operand_a = 32'd5; operand_b = 32'd0;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_fix_done", 32'(done), 32'd0);
    check("flush_fix_result", result, 32'd2);
    @(negedge clk);
    flush = 1'b0;
    check("flush_fix_state", 32'(dbg_state), 32'd0);
    check("flush_fix_result_kept", result, 32'd2);

    // Asynchronous reset at T+12 of a new op
    @(negedge clk);
    start = 1'b1; op = OP_DIVU; operand_a = 32'd1000; operand_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i < 12; i++) @(negedge clk);
    check("pre_reset_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_busy", 32'(busy), 32'd0);
    check("mid_reset_result", result, 32'd0);
    check("mid_reset_done", 32'(done), 32'd0);
    check("mid_reset_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("post_reset_no_done", 32'(dones), 32'd0);
    check("post_reset_result", result, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
